// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXEC/MEM sequencer for a small RV32I subset.
// Owns the PC and IR and drives datapath controls, immediates and memory handshakes.
module multicycle_controller #(
    parameter int unsigned NBITS      = 8,
    parameter int unsigned NREGS      = 32,
    parameter int unsigned WIDTH_ALUF = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [NBITS-1:0]         imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     dmem_req,
    output logic                     dmem_we,
    input  logic                     dmem_ack,
    output logic [$clog2(NREGS)-1:0] RS1,
    output logic [$clog2(NREGS)-1:0] RS2,
    output logic [$clog2(NREGS)-1:0] RD,
    output logic [NBITS-1:0]         IMM,
    output logic [WIDTH_ALUF-1:0]    ALUControl,
    output logic                     ALUSrc,
    output logic                     MemtoReg,
    output logic                     RegWrite,
    output logic                     link,
    output logic [NBITS-1:0]         pclink,
    input  logic [NBITS-1:0]         PCReg,
    input  logic                     Zero,
    output logic                     trap
);

    localparam int unsigned RegW = $clog2(NREGS);

    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcReg    = 7'b0110011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;

    localparam logic [WIDTH_ALUF-1:0] AluAdd = WIDTH_ALUF'(0);
    localparam logic [WIDTH_ALUF-1:0] AluXor = WIDTH_ALUF'(4);
    localparam logic [WIDTH_ALUF-1:0] AluSub = WIDTH_ALUF'(8);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StTrap} state_e;

    typedef enum logic [3:0] {
        InsIllegal, InsAddi, InsXori, InsAdd, InsXor, InsBeq, InsJal, InsJalr, InsLw, InsSw
    } ins_e;

    state_e                  state_q, state_d;
    logic [NBITS-1:0]        pc_q, pc_d;
    logic [31:0]             ir_q, ir_d;

    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic [6:0]              funct7;
    ins_e                    ins;
    logic [31:0]             imm_full;
    logic [WIDTH_ALUF-1:0]   alu_ctl;
    logic                    alu_src;
    logic [NBITS-1:0]        pc_plus4;
    logic [NBITS-1:0]        pc_plus_imm;
    logic [NBITS-1:0]        jalr_target;
    logic                    unused_imm;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];

    always_comb begin
        ins      = InsIllegal;
        imm_full = '0;
        alu_ctl  = AluAdd;
        alu_src  = 1'b0;
        case (opcode)
            OpcImm: begin
                imm_full = {{20{ir_q[31]}}, ir_q[31:20]};
                alu_src  = 1'b1;
                if (funct3 == 3'b000) begin
                    ins = InsAddi;
                end else if (funct3 == 3'b100) begin
                    ins     = InsXori;
                    alu_ctl = AluXor;
                end
            end
            OpcReg: begin
                if (funct7 == 7'b0000000 && funct3 == 3'b000) begin
                    ins = InsAdd;
                end else if (funct7 == 7'b0000000 && funct3 == 3'b100) begin
                    ins     = InsXor;
                    alu_ctl = AluXor;
                end
            end
            OpcBranch: begin
                imm_full = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
                alu_ctl  = AluSub;
                if (funct3 == 3'b000) ins = InsBeq;
            end
            OpcJal: begin
                imm_full = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
                ins      = InsJal;
            end
            OpcJalr: begin
                imm_full = {{20{ir_q[31]}}, ir_q[31:20]};
                if (funct3 == 3'b000) ins = InsJalr;
            end
            OpcLoad: begin
                imm_full = {{20{ir_q[31]}}, ir_q[31:20]};
                alu_src  = 1'b1;
                if (funct3 == 3'b010) ins = InsLw;
            end
            OpcStore: begin
                imm_full = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
                alu_src  = 1'b1;
                if (funct3 == 3'b010) ins = InsSw;
            end
            default: ;
        endcase
        // Illegal words present a quiet datapath rather than half-decoded fields.
        if (ins == InsIllegal) begin
            imm_full = '0;
            alu_ctl  = AluAdd;
            alu_src  = 1'b0;
        end
    end

    assign RS1        = ir_q[15 +: RegW];
    assign RS2        = ir_q[20 +: RegW];
    assign RD         = ir_q[7 +: RegW];
    assign IMM        = imm_full[NBITS-1:0];
    assign unused_imm = ^imm_full[31:NBITS];
    assign imem_addr  = pc_q;

    assign pc_plus4    = pc_q + NBITS'(4);
    assign pc_plus_imm = pc_q + IMM;
    assign jalr_target = (PCReg + IMM) & ~NBITS'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ALUControl = '0;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        link       = 1'b0;
        pclink     = '0;
        trap       = 1'b0;
        unique case (state_q)
            StFetch: begin
                // Gate with reset so the request drops the instant reset asserts.
                imem_req = reset;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                ALUControl = alu_ctl;
                ALUSrc     = alu_src;
                pclink     = pc_plus4;
                state_d    = (ins == InsIllegal) ? StTrap : StExec;
            end
            StExec: begin
                ALUControl = alu_ctl;
                ALUSrc     = alu_src;
                pclink     = pc_plus4;
                pc_d       = pc_plus4;
                state_d    = StFetch;
                case (ins)
                    InsAddi, InsXori, InsAdd, InsXor: RegWrite = 1'b1;
                    InsBeq: if (Zero) pc_d = pc_plus_imm;
                    InsJal: begin
                        link     = 1'b1;
                        RegWrite = 1'b1;
                        pc_d     = pc_plus_imm;
                    end
                    InsJalr: begin
                        link     = 1'b1;
                        RegWrite = 1'b1;
                        pc_d     = jalr_target;
                    end
                    InsLw, InsSw: begin
                        pc_d    = pc_q;
                        state_d = StMem;
                    end
                    default: state_d = StTrap;
                endcase
            end
            StMem: begin
                ALUControl = alu_ctl;
                ALUSrc     = alu_src;
                dmem_req   = 1'b1;
                dmem_we    = (ins == InsSw);
                if (dmem_ack) begin
                    if (ins == InsLw) begin
                        MemtoReg = 1'b1;
                        RegWrite = 1'b1;
                    end
                    pc_d    = pc_plus4;
                    state_d = StFetch;
                end
            end
            StTrap: trap = 1'b1;
            default: state_d = StFetch;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: program image in a local imem, delayed-ack dmem,
// register-write scoreboard keyed on cycle number, and spot checks of PC and controls.
module tb_multicycle_controller;

    localparam logic [31:0] InsSw      = 32'h00502423; // sw   x5,8(x0)
    localparam logic [31:0] InsAddi    = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] InsXori    = 32'h0030C113; // xori x2,x1,3
    localparam logic [31:0] InsLw      = 32'h00402183; // lw   x3,4(x0)
    localparam logic [31:0] InsAdd     = 32'h00208233; // add  x4,x1,x2
    localparam logic [31:0] InsBeq     = 32'hFE000CE3; // beq  x0,x0,-8
    localparam logic [31:0] InsJalX0p8 = 32'h0080006F; // jal  x0,+8
    localparam logic [31:0] InsJalFar  = 32'h0E40006F; // jal  x0,+228
    localparam logic [31:0] InsJalX1   = 32'h00C000EF; // jal  x1,+12
    localparam logic [31:0] InsJalr    = 32'h000080E7; // jalr x1,x1,0
    localparam logic [31:0] InsBad     = 32'h0000007F;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [7:0]  imem_addr, IMM, pclink, PCReg;
    logic [31:0] imem_rdata;
    logic [4:0]  RS1, RS2, RD;
    logic [3:0]  ALUControl;
    logic        ALUSrc, MemtoReg, RegWrite, link, Zero, trap;

    multicycle_controller #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .RS1(RS1), .RS2(RS2), .RD(RD), .IMM(IMM), .ALUControl(ALUControl), .ALUSrc(ALUSrc),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .link(link), .pclink(pclink),
        .PCReg(PCReg), .Zero(Zero), .trap(trap)
    );

    always #5 clock = ~clock;

    logic [31:0] imem [64];
    assign imem_rdata = imem[imem_addr[7:2]];
    assign imem_ack   = imem_req;

    int dmem_delay;
    int dwait;
    always @(posedge clock) begin
        if (!dmem_req || dmem_ack) dwait <= 0;
        else dwait <= dwait + 1;
    end
    assign dmem_ack = dmem_req && (dwait == dmem_delay);

    int cnt;
    always @(posedge clock) cnt <= cnt + 1;

    function automatic logic [31:0] mk(int c, logic [4:0] rd, logic m, logic l, logic [7:0] p);
        return {1'b0, 16'(c), rd, m, l, p};
    endfunction

    logic [31:0] act_q[$];
    logic [31:0] exp_q[$];
    int ireq_n, dreq_n, dwe_n, m2r_n;
    always @(negedge clock) begin
        if (RegWrite) act_q.push_back(mk(cnt, RD, MemtoReg, link, link ? pclink : 8'h00));
        if (imem_req) ireq_n <= ireq_n + 1;
        if (dmem_req) dreq_n <= dreq_n + 1;
        if (dmem_req && dmem_we) dwe_n <= dwe_n + 1;
        if (MemtoReg) m2r_n <= m2r_n + 1;
    end

    int nvec, nerr, base, d0, w0, i0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic smp(int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic goto(int k);
        while (cnt - base < k) @(negedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        Zero       = 1'b0;
        PCReg      = 8'h00;
        dmem_delay = 10;
        for (int i = 0; i < 64; i++) imem[i] = InsBad;
        imem[0] = InsSw;
        smp(2);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_trap", trap, 0);
        chk("rst_imm", IMM, 0);
        chk("rst_pclink", pclink, 0);

        // Reset while a store waits for its ack.
        reset = 1'b1;
        smp(3);
        chk("sw_dmem_req", dmem_req, 1);
        chk("sw_dmem_we", dmem_we, 1);
        smp(1);
        reset = 1'b0;
        #1;
        chk("abort_dmem_req", dmem_req, 0);
        chk("abort_imem_req", imem_req, 0);
        chk("abort_pc", imem_addr, 0);
        chk("abort_regwrite", RegWrite, 0);

        imem[0]    = InsAddi;
        imem[1]    = InsXori;
        imem[2]    = InsLw;
        imem[3]    = InsAdd;
        imem[4]    = InsBeq;
        dmem_delay = 3;
        smp(1);
        chk("rst_hold_imem_req", imem_req, 0);
        base  = cnt;
        reset = 1'b1;
        #1;
        chk("post_rst_imem_req", imem_req, 1);
        chk("post_rst_pc", imem_addr, 0);
        chk("sw_no_write", act_q.size(), 0);
        exp_q.push_back(mk(base + 2, 5'd1, 1'b0, 1'b0, 8'd0));
        exp_q.push_back(mk(base + 5, 5'd2, 1'b0, 1'b0, 8'd0));
        exp_q.push_back(mk(base + 12, 5'd3, 1'b1, 1'b0, 8'd0));
        exp_q.push_back(mk(base + 15, 5'd4, 1'b0, 1'b0, 8'd0));

        goto(2);
        chk("addi_alu", ALUControl, 4'b0000);
        chk("addi_src", ALUSrc, 1);
        goto(5);
        chk("xori_alu", ALUControl, 4'b0100);
        chk("xori_rs1", RS1, 1);
        goto(6);
        chk("pc_after_xori", imem_addr, 8);
        chk("fetch_req", imem_req, 1);
        d0 = dreq_n;
        w0 = dwe_n;
        goto(8);
        chk("lw_alu", ALUControl, 4'b0000);
        chk("lw_src", ALUSrc, 1);
        goto(13);
        chk("pc_after_lw", imem_addr, 12);
        chk("lw_dreq_cycles", dreq_n - d0, 4);
        chk("lw_we_cycles", dwe_n - w0, 0);
        goto(15);
        chk("add_src", ALUSrc, 0);
        chk("add_rs2", RS2, 2);
        goto(16);
        chk("pc_beq1", imem_addr, 16);
        Zero     = 1'b1;
        PCReg    = 8'h37;
        imem[2]  = InsJalX0p8;
        imem[5]  = InsJalFar;
        imem[62] = InsJalX1;
        imem[1]  = InsJalr;
        exp_q.push_back(mk(base + 21, 5'd0, 1'b0, 1'b1, 8'd12));
        exp_q.push_back(mk(base + 27, 5'd0, 1'b0, 1'b1, 8'd24));
        exp_q.push_back(mk(base + 30, 5'd1, 1'b0, 1'b1, 8'd252));
        exp_q.push_back(mk(base + 33, 5'd1, 1'b0, 1'b1, 8'd8));
        goto(18);
        chk("beq_alu", ALUControl, 4'b1000);
        chk("beq_imm", IMM, 8'hF8);
        goto(19);
        chk("beq_taken_pc", imem_addr, 8);
        goto(22);
        chk("pc_beq2", imem_addr, 16);
        Zero = 1'b0;
        goto(25);
        chk("beq_not_taken_pc", imem_addr, 20);
        goto(28);
        chk("jal_far_pc", imem_addr, 248);
        goto(31);
        chk("jal_wrap_pc", imem_addr, 4);
        goto(34);
        chk("jalr_pc", imem_addr, 8'h36);
        goto(35);
        i0 = ireq_n;
        goto(36);
        chk("trap_set", trap, 1);
        chk("trap_imem_req", imem_req, 0);
        goto(42);
        chk("trap_sticky", trap, 1);
        chk("trap_no_fetch", ireq_n - i0, 0);
        chk("trap_pc_frozen", imem_addr, 8'h36);

        while (exp_q.size() > 0) begin
            if (act_q.size() == 0) chk("regwrite_missing", 32'hFFFF_FFFF, exp_q.pop_front());
            else chk("regwrite", act_q.pop_front(), exp_q.pop_front());
        end
        chk("regwrite_extra", act_q.size(), 0);
        chk("memtoreg_cycles", m2r_n, 1);

        reset = 1'b0;
        #1;
        chk("trap_cleared", trap, 0);
        chk("trap_reset_pc", imem_addr, 0);
        smp(1);
        reset = 1'b1;
        smp(1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
